// File: rtl/inst_encoder.sv
// Encodes RV32I instruction requests into 32-bit words and streams them into an
// instruction memory at consecutive word addresses starting at BASE_ADDR.
module inst_encoder #(
  parameter int unsigned DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_req_vld,
  output logic                     o_req_rdy,
  input  logic [3:0]               i_class,
  input  logic [2:0]               i_funct3,
  input  logic                     i_alt,
  input  logic [4:0]               i_rd,
  input  logic [4:0]               i_rs1,
  input  logic [4:0]               i_rs2,
  input  logic [31:0]              i_imm,
  output logic                     o_imem_wren,
  output logic [31:0]              o_imem_addr,
  output logic [31:0]              o_imem_wdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_IALU   = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          err;
  logic          accept;
  logic          legal;
  logic [31:0]   word;

  logic fits_i, fits_b, fits_j, fits_u, fits_shamt, is_shift;

  // Range checks on the signed immediate: the upper bits must be a pure sign extension.
  assign fits_i     = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign fits_b     = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
  assign fits_j     = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
  assign fits_u     = ~(|i_imm[11:0]);
  assign fits_shamt = ~(|i_imm[31:5]);
  assign is_shift   = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

  always_comb begin
    legal = 1'b0;
    word  = '0;
    case (i_class)
      C_R: begin
        legal = 1'b1;
        word  = {(i_alt ? 7'b0100000 : 7'b0000000), i_rs2, i_rs1, i_funct3, i_rd, OP_R};
      end
      C_IALU: begin
        if (is_shift) begin
          legal = fits_shamt;
          word  = {1'b0, i_alt, 5'b00000, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_IALU};
        end else begin
          legal = fits_i;
          word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IALU};
        end
      end
      C_LOAD: begin
        legal = fits_i && (i_funct3 != 3'b011) && (i_funct3 != 3'b110) && (i_funct3 != 3'b111);
        word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      end
      C_STORE: begin
        legal = fits_i && (i_funct3 <= 3'b010);
        word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
      end
      C_BRANCH: begin
        legal = fits_b && (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
        word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], OP_BRANCH};
      end
      C_JAL: begin
        legal = fits_j;
        word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
      end
      C_JALR: begin
        legal = fits_i;
        word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, OP_JALR};
      end
      C_LUI: begin
        legal = fits_u;
        word  = {i_imm[31:12], i_rd, OP_LUI};
      end
      C_AUIPC: begin
        legal = fits_u;
        word  = {i_imm[31:12], i_rd, OP_AUIPC};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  // i_start wins over a simultaneous request, so the handshake is withheld that cycle.
  assign o_req_rdy = (state == S_RUN) && !i_start;
  assign accept    = i_req_vld && o_req_rdy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      count        <= '0;
      err          <= 1'b0;
      o_imem_wren  <= 1'b0;
      o_imem_addr  <= BASE_ADDR;
      o_imem_wdata <= '0;
    end else begin
      o_imem_wren <= 1'b0;
      if (i_start) begin
        state <= S_RUN;
        count <= '0;
        err   <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          o_imem_wren  <= 1'b1;
          o_imem_addr  <= BASE_ADDR + (32'(count) << 2);
          o_imem_wdata <= word;
          count        <= count + 1'b1;
          if (count == LAST) state <= S_FULL;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign o_count = count;
  assign o_full  = (state == S_FULL);
  assign o_err   = err;

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed spot checks plus randomized requests
// checked against a field-arithmetic reference model.
module tb_inst_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_reset, i_start, i_req_vld, i_alt;
  logic [3:0]    i_class;
  logic [2:0]    i_funct3;
  logic [4:0]    i_rd, i_rs1, i_rs2;
  logic [31:0]   i_imm;
  logic          o_req_rdy, o_imem_wren, o_full, o_err;
  logic [31:0]   o_imem_addr, o_imem_wdata;
  logic [CW-1:0] o_count;

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_req_vld(i_req_vld),
    .o_req_rdy(o_req_rdy), .i_class(i_class), .i_funct3(i_funct3), .i_alt(i_alt),
    .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_imem_wren(o_imem_wren), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
    .o_count(o_count), .o_full(o_full), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] expq[$];

  int m_state;
  int m_cnt;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(input int cls, input int f3, input logic [31:0] imm);
    int s;
    s = int'(imm);
    case (cls)
      0: return 1'b1;
      1: if (f3 == 1 || f3 == 5) return s >= 0 && s <= 31;
         else return s >= -2048 && s <= 2047;
      2: return s >= -2048 && s <= 2047 && !(f3 == 3 || f3 == 6 || f3 == 7);
      3: return s >= -2048 && s <= 2047 && f3 <= 2;
      4: return s >= -4096 && s <= 4094 && (s % 2) == 0 && f3 != 2 && f3 != 3;
      5: return s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2) == 0;
      6: return s >= -2048 && s <= 2047;
      7, 8: return (imm % 4096) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_encode(input int cls, input int f3, input bit alt,
                                           input int rd, input int rs1, input int rs2,
                                           input logic [31:0] imm);
    logic [31:0] r, a, b, f;
    r = 32'(rd) * 128;
    a = 32'(rs1) * 32768;
    b = 32'(rs2) * 1048576;
    f = 32'(f3) * 4096;
    case (cls)
      0: return (alt ? 32'h4000_0000 : 32'h0) + b + a + f + r + 32'h33;
      1: if (f3 == 1 || f3 == 5)
           return (alt ? 32'h4000_0000 : 32'h0) + (imm % 32) * 1048576 + a + f + r + 32'h13;
         else
           return (imm % 4096) * 1048576 + a + f + r + 32'h13;
      2: return (imm % 4096) * 1048576 + a + f + r + 32'h03;
      3: return ((imm / 32) % 128) * 33554432 + b + a + f + (imm % 32) * 128 + 32'h23;
      4: return ((imm / 4096) % 2) * 32'h8000_0000 + ((imm / 32) % 64) * 33554432 + b + a + f
                + ((imm / 2) % 16) * 256 + ((imm / 2048) % 2) * 128 + 32'h63;
      5: return ((imm / 1048576) % 2) * 32'h8000_0000 + ((imm / 2) % 1024) * 2097152
                + ((imm / 2048) % 2) * 1048576 + ((imm / 4096) % 256) * 4096 + r + 32'h6F;
      6: return (imm % 4096) * 1048576 + a + r + 32'h67;
      7: return (imm - imm % 4096) + r + 32'h37;
      8: return (imm - imm % 4096) + r + 32'h17;
      default: return 32'h0;
    endcase
  endfunction

  // One cycle: drive at posedge+1, check status at negedge, advance the model.
  task automatic step(input bit start, input bit vld, input logic [3:0] cls, input logic [2:0] f3,
                      input bit alt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input bit use_k, input logic [31:0] k);
    logic [31:0] w;
    i_start = start; i_req_vld = vld; i_class = cls; i_funct3 = f3; i_alt = alt;
    i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    @(negedge i_clk);
    check("req_rdy", 32'(o_req_rdy), 32'(m_state == 1 && !start));
    check("count", 32'(o_count), 32'(m_cnt));
    check("full", 32'(o_full), 32'(m_state == 2));
    check("err", 32'(o_err), 32'(m_err));
    if (start) begin
      m_state = 1; m_cnt = 0; m_err = 1'b0;
    end else if (vld && m_state == 1) begin
      if (m_legal(int'(cls), int'(f3), imm)) begin
        w = use_k ? k : m_encode(int'(cls), int'(f3), alt, int'(rd), int'(rs1), int'(rs2), imm);
        expq.push_back({BASE + 32'(m_cnt) * 4, w});
        m_cnt++;
        if (m_cnt == DEPTH) m_state = 2;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic do_start();
    step(1, 0, 4'd0, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'd0);
  endtask

  task automatic addi(input logic [4:0] rd, input logic [31:0] imm);
    step(0, 1, 4'd1, 3'd0, 0, rd, 5'd0, 5'd0, imm, 0, 32'd0);
  endtask

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge i_clk);
      if (o_imem_wren === 1'b1) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_wren: addr %h data %h, none expected at %0t",
                   o_imem_addr, o_imem_wdata, $time);
        end else begin
          e = expq.pop_front();
          check("imem_addr", o_imem_addr, e[63:32]);
          check("imem_wdata", o_imem_wdata, e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  cls;
    logic [31:0] imm;
    bit          st, vld;
    i_reset = 1'b1; i_start = 1'b0; i_req_vld = 1'b0; i_class = '0; i_funct3 = '0;
    i_alt = 1'b0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
    m_state = 0; m_cnt = 0; m_err = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_rdy", 32'(o_req_rdy), 32'd0);
    check("rst_wren", 32'(o_imem_wren), 32'd0);
    check("rst_addr", o_imem_addr, BASE);
    check("rst_wdata", o_imem_wdata, 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;

    // Requests before any start are ignored.
    addi(5'd1, 32'd5);
    do_start();
    step(0, 1, 4'd1, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h00500093);
    step(0, 1, 4'd0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3);
    step(0, 1, 4'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'hFE208EE3);
    step(0, 1, 4'd4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'd0);
    step(0, 1, 4'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1, 32'h001000EF);
    addi(5'd2, 32'd1);
    idle();

    // Start collides with a request while the previous write is still in flight.
    do_start();
    addi(5'd4, 32'd7);
    step(1, 1, 4'd1, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'd9, 0, 32'd0);
    idle();

    // Fill to DEPTH back-to-back after an illegal request, then restart.
    do_start();
    step(0, 1, 4'd9, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd0, 0, 32'd0);
    for (int i = 0; i < 5; i++) addi(5'(i + 1), 32'(i * 3));
    idle();
    do_start();
    idle();

    // Reset while the accepted write is on the output registers.
    addi(5'd6, 32'd11);
    i_reset = 1'b1; i_req_vld = 1'b0;
    expq.delete();
    m_state = 0; m_cnt = 0; m_err = 1'b0;
    @(negedge i_clk);
    check("mid_rst_wren", 32'(o_imem_wren), 32'd0);
    check("mid_rst_rdy", 32'(o_req_rdy), 32'd0);
    check("mid_rst_addr", o_imem_addr, BASE);
    check("mid_rst_wdata", o_imem_wdata, 32'd0);
    check("mid_rst_count", 32'(o_count), 32'd0);
    check("mid_rst_full", 32'(o_full), 32'd0);
    check("mid_rst_err", 32'(o_err), 32'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    addi(5'd7, 32'd1);
    addi(5'd7, 32'd2);

    for (int n = 0; n < 600; n++) begin
      st  = (m_state != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) cls = 4'($urandom_range(9, 15));
      else cls = 4'($urandom_range(0, 8));
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4400)) - 32'd2200;
        1: imm = 32'($urandom_range(0, (1 << 21) + 200)) - 32'((1 << 20) + 100);
        2: begin
          imm = $urandom & 32'hFFFF_F000;
          if ($urandom_range(0, 3) == 0) imm = imm | 32'h0000_0010;
        end
        default: imm = 32'($urandom_range(0, 40));
      endcase
      step(st, vld, cls, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom), 5'($urandom), 5'($urandom), imm, 0, 32'd0);
    end

    repeat (3) idle();
    check("pending_writes", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
